// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle control sequencer
package ctrl_pkg;

  // Sequencer state encodings (visible on the state port)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // Major opcodes the sequencer distinguishes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Next-PC mux select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Register-file write-back mux select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // States in which the datapath is doing useful work (counted by cycle_cnt)
  function automatic logic is_active(input logic [2:0] s);
    return (s >= ST_FETCH) && (s <= ST_WB);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - bounded wait counter shared by instruction and data fetch
module mem_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  output logic limit
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] cnt;

  // Counts cycles a request waits without ready; holds once the limit is reached
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (count && !limit) begin
      cnt <= cnt + W'(1);
    end
  end

  // limit is high on the LIMIT-th waiting cycle, so a still-low ready then times out
  assign limit = (cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic [6:0]       op,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             reg_we,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             retire;
  logic             wait_clear;
  logic             wait_count;
  logic             wait_limit;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // Restart the wait count on every state change so each FETCH/MEM visit starts at zero
  assign wait_clear = rst || (state_d != state_q);
  assign wait_count = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait (
    .clk   (clk),
    .clear (wait_clear),
    .count (wait_count),
    .limit (wait_limit)
  );

  // Next state and all datapath strobes, decoded from the registered state
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    retire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_limit) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        if (is_halt) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = (is_load || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            // Stores have nothing to write back, so they commit straight from MEM
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_limit) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        rf_we   = reg_we;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        case (op)
          OP_JAL:    pc_sel = PC_IMM;
          OP_JALR:   pc_sel = PC_ALU;
          OP_BRANCH: pc_sel = br_taken ? PC_IMM : PC_PLUS4;
          default:   pc_sel = PC_PLUS4;
        endcase
        if (is_load) begin
          wb_sel = WB_MEM;
        end else if ((op == OP_JAL) || (op == OP_JALR)) begin
          wb_sel = WB_PC4;
        end
      end
      default: begin
        // HALT and ERR are sticky until reset
        state_d = state_q;
      end
    endcase
  end

  // State register and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (is_active(state_q)) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == ST_HALT) || (state_q == ST_ERR);
  assign bus_err     = (state_q == ST_ERR);
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic        imem_ready;
  logic        ir_we;
  logic [6:0]  op = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        is_halt = 1'b0;
  logic        reg_we = 1'b0;
  logic        br_taken = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        halted;
  logic        bus_err;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .op(op), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .reg_we(reg_we), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ret_model = 0;
  int   cyc_model = 0;

  int   idly = 0;
  int   ddly = 0;
  bit   imem_en = 1'b1;
  bit   dmem_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory responder: raise ready after a programmed number of waiting cycles
  initial begin
    int icnt = 0;
    int dcnt = 0;
    logic [2:0] prev_st = 3'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      icnt = (state == ST_FETCH && prev_st == ST_FETCH) ? icnt + 1 : 0;
      dcnt = (state == ST_MEM && prev_st == ST_MEM) ? dcnt + 1 : 0;
      imem_ready = imem_en && (state == ST_FETCH) && (icnt >= idly);
      dmem_ready = dmem_en && (state == ST_MEM) && (dcnt >= ddly);
      prev_st = state;
    end
  end

  // Monitor: every commit pops the expected record and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pc_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("commit_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("commit_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
          chk("commit_wb_sel", 32'(wb_sel), 32'(e.wb_sel));
          chk("commit_rf_we", 32'(rf_we), 32'(e.rf_we));
          chk("commit_dmem_req", 32'(dmem_req), 32'(e.dmem_req));
          chk("commit_dmem_we", 32'(dmem_we), 32'(e.dmem_we));
          chk("commit_instret", instret_cnt, e.instret);
        end
      end
    end
  end

  // Runs one instruction from FETCH entry to its commit (or to DECODE for halt)
  task automatic run_instr(input string nm, input logic [6:0] o, input bit ld, input bit st,
                           input bit hl, input bit rw, input bit br, input int id, input int dd,
                           input logic [1:0] e_pc, input logic [1:0] e_wb, input bit e_rf,
                           input logic [31:0] e_trace, input int e_lat, input int e_dreq);
    exp_t e;
    int lat = 0;
    int dreq = 0;
    logic [31:0] trace = '0;
    bit done = 1'b0;
    op = o; is_load = ld; is_store = st; is_halt = hl; reg_we = rw; br_taken = br;
    idly = id; ddly = dd;
    if (!hl) begin
      e.pc_sel = e_pc; e.wb_sel = e_wb; e.rf_we = e_rf;
      e.dmem_req = st; e.dmem_we = st; e.instret = 32'(ret_model);
      exp_q.push_back(e);
    end
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
      trace = {trace[27:0], 1'b0, state};
      if (dmem_req) dreq++;
      if (pc_we || (state == ST_DECODE && is_halt)) done = 1'b1;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_trace"}, trace, e_trace);
    chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
    chk({nm, "_dmem_req_cycles"}, 32'(dreq), 32'(e_dreq));
    ret_model++;
    cyc_model += lat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_instret_cnt", instret_cnt, 32'd0);
    chk("rst_strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}), 32'd0);
    chk("rst_selects", 32'({pc_sel, wb_sel}), 32'd0);
    chk("rst_flags", 32'({halted, bus_err}), 32'd0);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_to_fetch", 32'(state), 32'(ST_FETCH));

    //        name        op            ld st hl rw br id dd pc     wb     rf trace          lat dreq
    run_instr("alu",      7'b0110011,   0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 32'h1235,     4, 0);
    chk("alu_instret", instret_cnt, 32'd1);
    chk("alu_cycle_cnt", cycle_cnt, 32'd4);
    run_instr("load",     7'b0000011,   1, 0, 0, 1, 0, 0, 3, 2'b00, 2'b01, 1, 32'h12344445, 8, 4);
    run_instr("store",    7'b0100011,   0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h1234,     4, 1);
    run_instr("br_taken", 7'b1100011,   0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 32'h1235,     4, 0);
    run_instr("br_not",   7'b1100011,   0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h1235,     4, 0);
    run_instr("jalr",     7'b1100111,   0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b10, 1, 32'h1235,     4, 0);
    run_instr("jal",      7'b1101111,   0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 1, 32'h1235,     4, 0);
    run_instr("alu_iwait",7'b0110011,   0, 0, 0, 1, 0, 2, 0, 2'b00, 2'b00, 1, 32'h111235,   6, 0);
    run_instr("halt",     7'b0000000,   0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h12,       2, 0);
    chk("halt_state", 32'(state), 32'(ST_HALT));
    chk("halt_flags", 32'({halted, bus_err}), 32'b10);
    chk("halt_instret", instret_cnt, 32'(ret_model));
    chk("halt_cycle_cnt", cycle_cnt, 32'(cyc_model));
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    chk("halt_sticky", 32'(state), 32'(ST_HALT));
    chk("halt_cycle_frozen", cycle_cnt, 32'(cyc_model));
    chk("halt_instret_frozen", instret_cnt, 32'(ret_model));

    // Reset while a load waits in MEM
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    op = 7'b0000011; is_load = 1'b1; is_store = 1'b0; is_halt = 1'b0; reg_we = 1'b1;
    dmem_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (state != ST_MEM && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reach_mem", 32'(state), 32'(ST_MEM));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cycle_state", 32'(state), 32'(ST_MEM));
    chk("mid_rst_cycle_dmem_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_after_state", 32'(state), 32'(ST_IDLE));
    chk("mid_after_dmem_req", 32'(dmem_req), 32'd0);
    chk("mid_after_counters", cycle_cnt | instret_cnt, 32'd0);
    dmem_en = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pc_we || rf_we) seen = 1'b1;
    end
    chk("mid_no_commit", 32'(seen), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Instruction fetch never answered: ERR after MEM_TIMEOUT waiting cycles
    is_load = 1'b0; reg_we = 1'b0;
    imem_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (state == ST_FETCH && n < 20) begin
      @(negedge clk);
      if (state == ST_FETCH) n++;
      @(posedge clk); #1;
    end
    chk("err_fetch_cycles", 32'(n), 32'd4);
    chk("err_state", 32'(state), 32'(ST_ERR));
    chk("err_flags", 32'({halted, bus_err}), 32'b11);
    chk("err_no_req", 32'({imem_req, dmem_req}), 32'd0);
    imem_en = 1'b1;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", 32'(state), 32'(ST_ERR));

    // start held high across reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(state), 32'(ST_IDLE));
    chk("rst_clears_err", 32'({halted, bus_err}), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    chk("rst_start_fetch", 32'(state), 32'(ST_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the single-issue CPU datapath (program counter, instruction memory, decoder, register file, ALU, data memory). Steps each instruction through fetch, decode, execute, memory and write-back. Generates every datapath write enable and mux select. Handles ready-based handshakes to both memories with a bounded wait, and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255, max cycles a memory request may wait for ready before entering ERR (≥1)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin fetching; ignored in other states
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction word valid this cycle
- ir_we  out  1  latch instruction register
- op  in  7  opcode field of latched IR
- is_load / is_store / is_halt / reg_we  in  1 each  decoder flags for latched IR
- br_taken  in  1  ALU branch-condition result
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- dmem_ready  in  1  data access complete this cycle
- pc_we  out  1  update program counter
- pc_sel  out  2  00 pc+4, 01 pc+imm, 10 ALU result (jalr)
- rf_we  out  1  register file write
- wb_sel  out  2  00 ALU, 01 memory data, 10 pc+4
- state  out  3  current state encoding
- halted  out  1  in HALT or ERR
- bus_err  out  1  in ERR
- cycle_cnt  out  CNT_W  active cycles
- instret_cnt  out  CNT_W  retired instructions

## Operation
States/encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, ERR 7.
- IDLE: all strobes 0; start → FETCH.
- FETCH: imem_req=1. imem_ready → ir_we=1, go to DECODE. Wait timeout → ERR.
- DECODE: is_halt → HALT, with instret+1. Otherwise → EXEC.
- EXEC: operands to ALU. is_load|is_store → MEM; otherwise → WB.
- MEM: dmem_req=1, dmem_we=is_store.
  - On dmem_ready with a store: pc_we=1, pc_sel=00, instret+1, → FETCH.
  - On dmem_ready with a load: → WB.
  - Wait timeout → ERR.
- WB: rf_we=reg_we, pc_we=1, instret+1, → FETCH.
  - pc_sel: jal (1101111) 01; jalr (1100111) 10; branch (1100011) 01 if br_taken else 00; other 00.
  - wb_sel: load 01; jal/jalr 10; other 00.
- HALT, ERR: sticky until rst; halted=1; ERR also bus_err=1; no requests.
- Wait counter: cleared on entry to FETCH/MEM; increments each cycle ready is low. Reaching MEM_TIMEOUT with ready low → ERR. Ready in the same cycle as the limit wins.
- cycle_cnt increments every cycle in states 1–5; wraps at 2^CNT_W. instret_cnt wraps likewise.

## Timing
- Reset values: state=IDLE, counters 0, wait counter 0. All strobes/selects 0, halted=0, bus_err=0.
- Strobes are combinational from registered state plus ready/decoder inputs.
- ir_we, pc_we on store commit, and MEM/FETCH exits are single-cycle, qualified by ready.
- Zero-wait latency: ALU/branch/jump 4 cycles (F,D,E,W); load 5 (F,D,E,M,W); store 4 (F,D,E,M); halt 2.
- Requests stay high continuously until ready; a ready seen outside FETCH/MEM is ignored.
- Reset mid-operation: outputs in the rst cycle reflect the old state. After the edge the state is IDLE and requests drop. No partial commit occurs afterward.
- start held high across reset: FETCH begins the cycle after rst deasserts.

## Structure
- Shared package ctrl_pkg: state encodings, opcode constants (LOAD 0000011, STORE 0100011, BRANCH, JAL, JALR), pc_sel/wb_sel encodings.
- One sub-module: mem_wait_timer (clear, count, limit-reached flag), shared by FETCH and MEM waits.

## Test plan
- Reset, start, ALU op (op=0110011, reg_we=1), zero-wait imem → states 1,2,3,5,1. rf_we=1 in WB; instret_cnt=1, cycle_cnt=4.
- Load with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, then WB with wb_sel=01. Instruction latency 8 cycles.
- Branch op=1100011: br_taken=1 → pc_sel=01; br_taken=0 → pc_sel=00, rf_we=0. jalr → pc_sel=10, wb_sel=10.
- MEM_TIMEOUT=4, imem_ready never asserted → ERR after 4 wait cycles; bus_err=1, halted=1. Stays there until rst.
- is_halt in DECODE → HALT. instret increments once; cycle_cnt frozen; later start ignored.
- rst asserted during MEM with dmem_req high → IDLE next cycle; counters 0; no pc_we/rf_we afterward.
